// File: rtl/calc_input_controller_if.sv
// Calculator control port bundle: button pulses in; state, cursors, operands and result out.
interface calc_input_controller_if #(
  parameter int NUM_W = 14,
  parameter int RES_W = 29
);
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_centre;
  logic [2:0]       state;
  logic [1:0]       op_selection;
  logic [3:0]       numpad_selection;
  logic [NUM_W-1:0] num1;
  logic [NUM_W-1:0] num2;
  logic [2:0]       digit_count;
  logic [RES_W-1:0] result;
  logic             div_by_zero;
  logic             result_valid;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_centre,
    input  state, op_selection, numpad_selection, num1, num2, digit_count,
           result, div_by_zero, result_valid
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_centre,
    output state, op_selection, numpad_selection, num1, num2, digit_count,
           result, div_by_zero, result_valid
  );
endinterface

// File: rtl/calc_input_controller.sv
// Calculator FSM: op choice, operand entry, add/sub/mul in 1 COMPUTE cycle, divide in NUM_W cycles.
// All outputs registered; buttons are fire-and-forget pulses, so there is no backpressure.
module calc_input_controller #(
  parameter int MAX_DIGITS = 4,
  parameter int NUM_W      = 14,
  parameter int RES_W      = 2*NUM_W+1
) (
  input logic                   clk,
  input logic                   reset,
  calc_input_controller_if.slave io
);
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [2:0] {
    S_CHOOSE_OP   = 3'd0,
    S_INPUT_NUM1  = 3'd1,
    S_INPUT_NUM2  = 3'd2,
    S_SHOW_RESULT = 3'd3,
    S_COMPUTE     = 3'd4
  } state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [3:0]       sel_q;
  logic [NUM_W-1:0] num1_q, num2_q;
  logic [2:0]       cnt_q;
  logic [RES_W-1:0] result_q;
  logic             dbz_q, rvld_q;
  logic [NUM_W-1:0] div_rem_q, div_quo_q;
  logic [CNT_W-1:0] div_cnt_q;

  logic [NUM_W-1:0] cur_num_d, append_d, bksp_d;
  logic [3:0]       digit_d, col_d, up_d, down_d, left_d, right_d;
  logic [RES_W-1:0] a_ext_d, b_ext_d, arith_d;
  logic [NUM_W:0]   div_shift_d, div_trial_d;
  logic             div_take_d;
  logic [NUM_W-1:0] div_rem_next_d, div_quo_next_d;

  always_comb begin
    cur_num_d = (state_q == S_INPUT_NUM2) ? num2_q : num1_q;
    digit_d   = (sel_q == 4'd10) ? 4'd0 : sel_q + 4'd1;
    append_d  = cur_num_d * NUM_W'(10) + NUM_W'(digit_d);
    bksp_d    = cur_num_d / NUM_W'(10);
    // 4x3 keypad, cursor wraps on every edge
    col_d     = sel_q % 4'd3;
    up_d      = (sel_q >= 4'd3) ? sel_q - 4'd3 : sel_q + 4'd9;
    down_d    = (sel_q <  4'd9) ? sel_q + 4'd3 : sel_q - 4'd9;
    left_d    = (col_d == 4'd0) ? sel_q + 4'd2 : sel_q - 4'd1;
    right_d   = (col_d == 4'd2) ? sel_q - 4'd2 : sel_q + 4'd1;
    a_ext_d   = RES_W'(num1_q);
    b_ext_d   = RES_W'(num2_q);
    case (op_q)
      2'b00:   arith_d = a_ext_d + b_ext_d;
      2'b01:   arith_d = a_ext_d - b_ext_d;
      default: arith_d = a_ext_d * b_ext_d;
    endcase
    // restoring divide: dividend shifts out of the quotient register MSB-first
    div_shift_d    = {div_rem_q, div_quo_q[NUM_W-1]};
    div_trial_d    = div_shift_d - {1'b0, num2_q};
    div_take_d     = ~div_trial_d[NUM_W];
    div_rem_next_d = div_take_d ? div_trial_d[NUM_W-1:0] : div_shift_d[NUM_W-1:0];
    div_quo_next_d = {div_quo_q[NUM_W-2:0], div_take_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CHOOSE_OP;
      op_q      <= '0;
      sel_q     <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      rvld_q    <= 1'b0;
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_cnt_q <= '0;
    end else begin
      rvld_q <= 1'b0;
      case (state_q)
        S_CHOOSE_OP: begin
          if (io.btn_centre) begin
            state_q <= S_INPUT_NUM1;
            num1_q  <= '0;
            num2_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
          end else if (io.btn_up || io.btn_down) begin
            op_q[1] <= ~op_q[1];
          end else if (io.btn_left || io.btn_right) begin
            op_q[0] <= ~op_q[0];
          end
        end
        S_INPUT_NUM1, S_INPUT_NUM2: begin
          if (io.btn_centre) begin
            if (sel_q == 4'd11) begin
              if (state_q == S_INPUT_NUM1) begin
                state_q <= S_INPUT_NUM2;
                cnt_q   <= '0;
                sel_q   <= '0;
              end else begin
                state_q   <= S_COMPUTE;
                div_rem_q <= '0;
                div_quo_q <= num1_q;
                div_cnt_q <= '0;
              end
            end else if (sel_q == 4'd9) begin
              if (cnt_q != 3'd0) begin
                if (state_q == S_INPUT_NUM1) num1_q <= bksp_d;
                else                         num2_q <= bksp_d;
                cnt_q <= cnt_q - 3'd1;
              end
            end else if (cnt_q < 3'(MAX_DIGITS)) begin
              if (state_q == S_INPUT_NUM1) num1_q <= append_d;
              else                         num2_q <= append_d;
              cnt_q <= cnt_q + 3'd1;
            end
          end else if (io.btn_up) begin
            sel_q <= up_d;
          end else if (io.btn_down) begin
            sel_q <= down_d;
          end else if (io.btn_left) begin
            sel_q <= left_d;
          end else if (io.btn_right) begin
            sel_q <= right_d;
          end
        end
        S_COMPUTE: begin
          if (op_q != 2'b11) begin
            result_q <= arith_d;
            state_q  <= S_SHOW_RESULT;
            rvld_q   <= 1'b1;
          end else if (num2_q == '0) begin
            result_q <= '0;
            dbz_q    <= 1'b1;
            state_q  <= S_SHOW_RESULT;
            rvld_q   <= 1'b1;
          end else begin
            div_rem_q <= div_rem_next_d;
            div_quo_q <= div_quo_next_d;
            div_cnt_q <= div_cnt_q + CNT_W'(1);
            if (div_cnt_q == CNT_W'(NUM_W-1)) begin
              result_q <= RES_W'(div_quo_next_d);
              state_q  <= S_SHOW_RESULT;
              rvld_q   <= 1'b1;
            end
          end
        end
        S_SHOW_RESULT: begin
          if (io.btn_centre) begin
            state_q  <= S_CHOOSE_OP;
            num1_q   <= '0;
            num2_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            sel_q    <= '0;
          end
        end
        default: state_q <= S_CHOOSE_OP;
      endcase
    end
  end

  assign io.state            = state_q;
  assign io.op_selection     = op_q;
  assign io.numpad_selection = sel_q;
  assign io.num1             = num1_q;
  assign io.num2             = num2_q;
  assign io.digit_count      = cnt_q;
  assign io.result           = result_q;
  assign io.div_by_zero      = dbz_q;
  assign io.result_valid     = rvld_q;
endmodule
